// File: rtl/clkdiv_controller_if.sv
// Configuration handshake bundle for clkdiv_controller: divide value offer plus burst length.
interface clkdiv_controller_if #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [DIV_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_count;

  modport master (
    output cfg_valid,
    output cfg_div,
    output cfg_count,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    input  cfg_count,
    output cfg_ready
  );
endinterface

// File: rtl/clkdiv_controller.sv
// Clock-divider sequencing controller: glitch-free divide changes at period boundaries, free-run/burst, clean stop.
// Optional output periods_o is enabled by defining CLKDIV_CTRL_PERIOD_CNT_EN.
module clkdiv_controller #(
  parameter int DIV_W       = 16,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                 in_clk_i,
  input  logic                 reset_i,
  clkdiv_controller_if.slave   cfg_if,
  input  logic                 start_i,
  input  logic                 stop_i,
  output logic                 out_clk_o,
  output logic                 tick_o,
  output logic                 busy_o,
  output logic                 done_o
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
  ,
  output logic [15:0]          periods_o
`endif
);

  localparam int DEF_DIV_SAFE = (DEFAULT_DIV < 1) ? 1 : DEFAULT_DIV;
  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEF_DIV_SAFE);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             outClk_q, outClk_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             pending_q, pending_d;
  logic [DIV_W-1:0] pendDiv_q, pendDiv_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
  logic [15:0]      periods_q, periods_d;
`endif

  logic capture;
  logic apply;
  logic boundary;
  logic lastPeriod;

  assign cfg_if.cfg_ready = ~pending_q;

  always_comb begin
    state_d     = state_q;
    outClk_d    = outClk_q;
    tick_d      = 1'b0;
    done_d      = 1'b0;
    cnt_d       = cnt_q;
    div_d       = div_q;
    pending_d   = pending_q;
    pendDiv_d   = pendDiv_q;
    remaining_d = remaining_q;
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
    periods_d   = periods_q;
`endif
    apply       = 1'b0;
    boundary    = 1'b0;
    lastPeriod  = 1'b0;
    capture     = cfg_if.cfg_valid && !pending_q;

    unique case (state_q)
      IDLE: begin
        outClk_d = 1'b0;
        cnt_d    = '0;
        apply    = pending_q;
        if (start_i) begin
          state_d     = RUN;
          remaining_d = cfg_if.cfg_count;
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
          periods_d   = '0;
`endif
        end
      end

      RUN, STOPPING: begin
        if (cnt_q == div_q - DIV_W'(1)) begin
          cnt_d    = '0;
          outClk_d = ~outClk_q;
          tick_d   = ~outClk_q;
          boundary = outClk_q;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end

        // A stop seen on a boundary edge is latched for the following period, never the one just ended.
        if (state_q == RUN && stop_i) begin
          state_d = STOPPING;
        end

        if (boundary) begin
          apply = pending_q;
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
          if (periods_q != 16'hFFFF) begin
            periods_d = periods_q + 16'd1;
          end
`endif
          if (remaining_q != '0) begin
            remaining_d = remaining_q - CNT_W'(1);
          end
          lastPeriod = (remaining_q == CNT_W'(1)) || (state_q == STOPPING);
          if (lastPeriod) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d  = IDLE;
        outClk_d = 1'b0;
        cnt_d    = '0;
      end
    endcase

    // apply and capture are exclusive: apply needs pending set, capture needs it clear.
    if (apply) begin
      div_d     = pendDiv_q;
      pending_d = 1'b0;
    end
    if (capture) begin
      pendDiv_d = (cfg_if.cfg_div == '0) ? DIV_W'(1) : cfg_if.cfg_div;
      pending_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge in_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      outClk_q    <= 1'b0;
      tick_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
      div_q       <= DEF_DIV;
      pending_q   <= 1'b0;
      pendDiv_q   <= DEF_DIV;
      remaining_q <= '0;
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
      periods_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      outClk_q    <= outClk_d;
      tick_q      <= tick_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      pending_q   <= pending_d;
      pendDiv_q   <= pendDiv_d;
      remaining_q <= remaining_d;
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
      periods_q   <= periods_d;
`endif
    end
  end

  assign out_clk_o = outClk_q;
  assign tick_o    = tick_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
  assign periods_o = periods_q;
`endif

endmodule
